// File: rtl/id_ex_issue_ctrl.sv
// ---------------------------------------------------------------------------
// id_ex_issue_ctrl
//
// Writer side of the ID/EX control-bundle interface. Every cycle this block
// chooses what the ID/EX register latches: the decoded control bundle, or an
// all-zero bubble when a load-use hazard is seen against the instruction in
// EX. It drives the PC and IF/ID load enables, sequences the IF/ID squash
// after a taken branch (the delay slot in ID always proceeds), and keeps a
// saturating count of inserted bubbles.
//
// Parameters:
//   CTRL_W        width of the control bundle
//   STALL_CYCLES  bubbles inserted per load-use hazard (1..7)
//
// Ports:
//   clk, reset                 clock; synchronous active-high reset
//   ctrl_in                    control bundle for the instruction in ID
//   id_rs, id_rt               source registers of the ID instruction
//   id_uses_rs, id_uses_rt     ID instruction really reads rs / rt
//   ex_load, ex_rf_enable      ID/EX holds a load / writes the register file
//   ex_rd                      destination register of the ID/EX instruction
//   branch_taken               taken branch resolved in EX (1-cycle pulse)
//   hold                       global freeze
//   ctrl_out                   bundle presented to ID/EX
//   id_ex_le, pc_le, if_id_le  load enables
//   if_id_flush                clear IF/ID to NOP on the next edge
//   bubble_cnt                 saturating bubble count
//   state                      0 = RUN, 1 = STALL
//
// Handshake: there is no valid/ready pair here; the load enables are the
// only flow control. A register advances on an edge exactly when its enable
// is high in the cycle before that edge, and all outputs are combinational
// from registered state plus the current inputs.
// ---------------------------------------------------------------------------
module id_ex_issue_ctrl #(
   parameter int CTRL_W       = 22,
   parameter int STALL_CYCLES = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [CTRL_W-1:0] ctrl_in,
   input  logic [4:0]        id_rs,
   input  logic [4:0]        id_rt,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic              ex_load,
   input  logic              ex_rf_enable,
   input  logic [4:0]        ex_rd,
   input  logic              branch_taken,
   input  logic              hold,
   output logic [CTRL_W-1:0] ctrl_out,
   output logic              id_ex_le,
   output logic              pc_le,
   output logic              if_id_le,
   output logic              if_id_flush,
   output logic [15:0]       bubble_cnt,
   output logic              state
);

   typedef enum logic {
      RUN   = 1'b0,
      STALL = 1'b1
   } state_t;

   // Remaining bubbles loaded on entry to STALL (the RUN cycle that saw the
   // hazard is the first bubble).
   localparam logic [2:0] REM_INIT = 3'(STALL_CYCLES - 1);

   state_t      state_q;
   logic [2:0]  rem_q;
   logic        flush_pend_q;
   logic [15:0] bubble_cnt_q;

   logic hazard;
   logic bubble;
   logic normal;

   assign hazard = ex_load & ex_rf_enable & (ex_rd != 5'd0) &
                   ((id_uses_rs & (id_rs == ex_rd)) |
                    (id_uses_rt & (id_rt == ex_rd)));

   // Reset and hold take priority; otherwise STALL forces a bubble no
   // matter what the hazard input says.
   assign bubble = ~reset & ~hold & ((state_q == STALL) | hazard);
   assign normal = ~reset & ~hold & ~bubble;

   always_comb begin
      ctrl_out    = '0;
      id_ex_le    = 1'b0;
      pc_le       = 1'b0;
      if_id_le    = 1'b0;
      if_id_flush = 1'b0;
      if (reset) begin
         ctrl_out = '0;
      end else if (hold) begin
         ctrl_out = ctrl_in;
      end else if (bubble) begin
         ctrl_out = '0;
         id_ex_le = 1'b1;
      end else begin
         ctrl_out    = ctrl_in;
         id_ex_le    = 1'b1;
         pc_le       = 1'b1;
         if_id_le    = 1'b1;
         // A pending flush and a fresh pulse collapse into one flush.
         if_id_flush = branch_taken | flush_pend_q;
      end
   end

   assign bubble_cnt = bubble_cnt_q;
   assign state      = state_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= RUN;
         rem_q        <= 3'd0;
         flush_pend_q <= 1'b0;
         bubble_cnt_q <= 16'd0;
      end else if (hold) begin
         // Frozen, but a branch resolved during the freeze must not be lost.
         flush_pend_q <= flush_pend_q | branch_taken;
      end else if (bubble) begin
         // IF/ID is not loading, so a squash has to wait for a normal cycle.
         flush_pend_q <= flush_pend_q | branch_taken;
         if (bubble_cnt_q != 16'hFFFF) begin
            bubble_cnt_q <= bubble_cnt_q + 16'd1;
         end
         if (state_q == RUN) begin
            if (STALL_CYCLES > 1) begin
               state_q <= STALL;
               rem_q   <= REM_INIT;
            end
         end else begin
            rem_q <= rem_q - 3'd1;
            if (rem_q == 3'd1) begin
               state_q <= RUN;
            end
         end
      end else if (normal) begin
         // Any pending flush is issued in this cycle.
         flush_pend_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_id_ex_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_id_ex_issue_ctrl
//
// Two instances (STALL_CYCLES = 1 and 3) share one stimulus stream. A
// reference model tracks "bubbles still owed" as a plain integer per
// instance and predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_id_ex_issue_ctrl;

   localparam int W = 22;

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] ctrl_in;
   logic [4:0]   id_rs, id_rt, ex_rd;
   logic         id_uses_rs, id_uses_rt, ex_load, ex_rf_enable;
   logic         branch_taken, hold;

   logic [1:0][W-1:0] ctrl_out_v;
   logic [1:0]        id_ex_le_v, pc_le_v, if_id_le_v, if_id_flush_v, state_v;
   logic [1:0][15:0]  bubble_cnt_v;

   int checks   = 0;
   int failures = 0;

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- DUTs -----------------
   id_ex_issue_ctrl #(.CTRL_W(W), .STALL_CYCLES(1)) u_dut1 (
      .clk(clk), .reset(reset), .ctrl_in(ctrl_in),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .ex_load(ex_load), .ex_rf_enable(ex_rf_enable), .ex_rd(ex_rd),
      .branch_taken(branch_taken), .hold(hold),
      .ctrl_out(ctrl_out_v[0]), .id_ex_le(id_ex_le_v[0]), .pc_le(pc_le_v[0]),
      .if_id_le(if_id_le_v[0]), .if_id_flush(if_id_flush_v[0]),
      .bubble_cnt(bubble_cnt_v[0]), .state(state_v[0])
   );

   id_ex_issue_ctrl #(.CTRL_W(W), .STALL_CYCLES(3)) u_dut3 (
      .clk(clk), .reset(reset), .ctrl_in(ctrl_in),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .ex_load(ex_load), .ex_rf_enable(ex_rf_enable), .ex_rd(ex_rd),
      .branch_taken(branch_taken), .hold(hold),
      .ctrl_out(ctrl_out_v[1]), .id_ex_le(id_ex_le_v[1]), .pc_le(pc_le_v[1]),
      .if_id_le(if_id_le_v[1]), .if_id_flush(if_id_flush_v[1]),
      .bubble_cnt(bubble_cnt_v[1]), .state(state_v[1])
   );

   // ---------------- reference model ----------------
   int n_of[2] = '{1, 3};
   int m_left[2];          // bubbles still owed after the current cycle
   int m_cnt[2];
   bit m_pend[2];
   int nx_left[2];
   int nx_cnt[2];
   bit nx_pend[2];
   bit do_cmp = 1'b1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic eval_and_check();
      bit hz;
      hz = ex_load && ex_rf_enable && (ex_rd != 0) &&
           ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
      for (int i = 0; i < 2; i++) begin
         logic [W-1:0] e_ctrl;
         bit e_id, e_pc, e_if, e_fl, bub;
         nx_left[i] = m_left[i];
         nx_cnt[i]  = m_cnt[i];
         nx_pend[i] = m_pend[i];
         e_ctrl = '0; e_id = 0; e_pc = 0; e_if = 0; e_fl = 0;
         if (reset) begin
            nx_left[i] = 0; nx_cnt[i] = 0; nx_pend[i] = 0;
         end else if (hold) begin
            e_ctrl = ctrl_in;
            nx_pend[i] = m_pend[i] | branch_taken;
         end else begin
            bub = (m_left[i] > 0) || hz;
            if (bub) begin
               e_id = 1;
               nx_pend[i] = m_pend[i] | branch_taken;
               nx_cnt[i]  = (m_cnt[i] >= 65535) ? 65535 : m_cnt[i] + 1;
               nx_left[i] = (m_left[i] > 0) ? m_left[i] - 1 : n_of[i] - 1;
            end else begin
               e_ctrl = ctrl_in;
               e_id = 1; e_pc = 1; e_if = 1;
               e_fl = branch_taken | m_pend[i];
               nx_pend[i] = 0;
            end
         end
         if (do_cmp) begin
            check($sformatf("n%0d_ctrl_out", n_of[i]), 32'(ctrl_out_v[i]), 32'(e_ctrl));
            check($sformatf("n%0d_id_ex_le", n_of[i]), 32'(id_ex_le_v[i]), 32'(e_id));
            check($sformatf("n%0d_pc_le", n_of[i]), 32'(pc_le_v[i]), 32'(e_pc));
            check($sformatf("n%0d_if_id_le", n_of[i]), 32'(if_id_le_v[i]), 32'(e_if));
            check($sformatf("n%0d_if_id_flush", n_of[i]), 32'(if_id_flush_v[i]), 32'(e_fl));
            check($sformatf("n%0d_bubble_cnt", n_of[i]), 32'(bubble_cnt_v[i]), 32'(m_cnt[i]));
            check($sformatf("n%0d_state", n_of[i]), 32'(state_v[i]), 32'(m_left[i] > 0));
         end
      end
   endtask

   // One clock: compare at the falling edge, commit the model after the
   // rising edge; the caller changes inputs after this returns.
   task automatic run_cycle();
      @(negedge clk);
      eval_and_check();
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         m_left[i] = nx_left[i];
         m_cnt[i]  = nx_cnt[i];
         m_pend[i] = nx_pend[i];
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      reset = 0; hold = 0; branch_taken = 0;
      ex_load = 0; ex_rf_enable = 0; ex_rd = 0;
      id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
   endtask

   task automatic drive_load_use_rs(input logic [4:0] rd);
      ex_load = 1; ex_rf_enable = 1; ex_rd = rd;
      id_rs = rd; id_uses_rs = 1; id_rt = 0; id_uses_rt = 0;
   endtask

   task automatic drive_random();
      ctrl_in      = W'($urandom);
      reset        = ($urandom_range(0, 99) < 2);
      hold         = ($urandom_range(0, 99) < 12);
      branch_taken = ($urandom_range(0, 99) < 15);
      ex_load      = ($urandom_range(0, 99) < 40);
      ex_rf_enable = ($urandom_range(0, 99) < 85);
      ex_rd        = 5'($urandom_range(0, 3));
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      id_uses_rs   = $urandom_range(0, 1);
      id_uses_rt   = $urandom_range(0, 1);
   endtask

   // ---------------- sequence ----------------
   initial begin
      for (int i = 0; i < 2; i++) begin
         m_left[i] = 0; m_cnt[i] = 0; m_pend[i] = 0;
      end
      ctrl_in = '0;
      idle_inputs();
      reset = 1;
      #1;
      run_cycle();
      run_cycle();
      reset = 0;

      // No hazard, constant bundle.
      ctrl_in = 22'h2AAAAA;
      for (int k = 0; k < 10; k++) run_cycle();
      check("no_hazard_cnt1", 32'(bubble_cnt_v[0]), 32'd0);
      check("no_hazard_cnt3", 32'(bubble_cnt_v[1]), 32'd0);

      // Load-use on rs; next cycle the bubble sits in EX.
      drive_load_use_rs(5'd8);
      run_cycle();
      idle_inputs();
      for (int k = 0; k < 4; k++) run_cycle();
      check("single_hazard_cnt1", 32'(bubble_cnt_v[0]), 32'd1);
      check("single_hazard_cnt3", 32'(bubble_cnt_v[1]), 32'd3);

      // Non-hazards: rd = 0, and rt match without rt use.
      drive_load_use_rs(5'd0);
      run_cycle();
      ex_load = 1; ex_rf_enable = 1; ex_rd = 8;
      id_rs = 3; id_uses_rs = 1; id_rt = 8; id_uses_rt = 0;
      run_cycle();
      idle_inputs();
      run_cycle();
      check("no_bubble_cnt1", 32'(bubble_cnt_v[0]), 32'd1);
      check("no_bubble_cnt3", 32'(bubble_cnt_v[1]), 32'd3);

      // Hazard, then hold for 2 cycles while the N=3 unit is stalled.
      drive_load_use_rs(5'd9);
      run_cycle();
      idle_inputs();
      hold = 1;
      run_cycle();
      run_cycle();
      hold = 0;
      for (int k = 0; k < 4; k++) run_cycle();
      check("hold_stall_cnt3", 32'(bubble_cnt_v[1]), 32'd6);
      check("hold_stall_state3", 32'(state_v[1]), 32'd0);

      // Branch in a normal cycle, then branch during a bubble.
      branch_taken = 1;
      run_cycle();
      branch_taken = 0;
      run_cycle();
      drive_load_use_rs(5'd5);
      branch_taken = 1;
      run_cycle();
      idle_inputs();
      for (int k = 0; k < 4; k++) run_cycle();

      // Randomized traffic.
      for (int k = 0; k < 1500; k++) begin
         drive_random();
         run_cycle();
      end

      // Saturation: a continuous hazard produces one bubble per cycle.
      idle_inputs();
      reset = 1;
      run_cycle();
      reset = 0;
      do_cmp = 0;
      drive_load_use_rs(5'd7);
      for (int k = 0; k < 65534; k++) run_cycle();
      do_cmp = 1;
      check("preset_cnt1", 32'(bubble_cnt_v[0]), 32'hFFFE);
      for (int k = 0; k < 4; k++) run_cycle();
      check("sat_cnt1", 32'(bubble_cnt_v[0]), 32'hFFFF);
      check("sat_cnt3", 32'(bubble_cnt_v[1]), 32'hFFFF);

      // Reset in the middle of a stall.
      idle_inputs();
      for (int k = 0; k < 4; k++) run_cycle();
      drive_load_use_rs(5'd4);
      run_cycle();
      idle_inputs();
      check("pre_reset_state3", 32'(state_v[1]), 32'd1);
      reset = 1;
      run_cycle();
      reset = 0;
      check("post_reset_state3", 32'(state_v[1]), 32'd0);
      check("post_reset_cnt3", 32'(bubble_cnt_v[1]), 32'd0);
      for (int k = 0; k < 3; k++) run_cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
